luma_edge_feeder: RTL and testbench

- Transmitter side of the luma deblocking pipeline. Per macroblock it scans all 4 vertical luma edges, then all 4 horizontal luma edges, 16 lines each.
- For each line it reads an 8-pixel p3..q3 vector from the MB pixel buffer and presents it to the filter pipeline together with bs and qp1/qp2.
- It takes the filtered vector back after the pipeline latency and writes it to the same buffer address.
- Sits between the deblocking top-level controller (start/done) and the filter pipeline plus pixel buffer.

---
 rtl/luma_edge_feeder_pkg.sv | 60 ++++++
 rtl/luma_edge_feeder_db_wr_delay.sv | 39 +++
 rtl/luma_edge_feeder.sv | 191 +++++++++++++++++++
 tb/tb_luma_edge_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/luma_edge_feeder_pkg.sv
// Shared deblocking definitions: FSM encoding, buffer address fields,
// pixel packing and scan geometry for the luma edge feeder.
package luma_edge_feeder_pkg;

    localparam int RD_LAT        = 1;
    localparam int PIPE_LAT_DEF  = 2;
    localparam int DRAIN_CYC     = RD_LAT + PIPE_LAT_DEF;
    localparam int LINES_PER_DIR = 64;
    localparam int LINE_CNT_W    = $clog2(LINES_PER_DIR);

    localparam int ADDR_W    = 7;
    localparam int ADDR_DIR  = 6;
    localparam int EDGE_MSB  = 5;
    localparam int EDGE_LSB  = 4;
    localparam int LINE_MSB  = 3;
    localparam int LINE_LSB  = 0;

    localparam int PIX_W    = 8;
    localparam int VEC_W    = 8 * PIX_W;
    localparam int QP_W     = 6;
    localparam int BS_W     = 3;
    localparam int BS_VEC_W = 16 * BS_W;

    // p3 sits in the top byte, q3 in the bottom byte
    localparam int P3_LSB = 56;
    localparam int P2_LSB = 48;
    localparam int P1_LSB = 40;
    localparam int P0_LSB = 32;
    localparam int Q0_LSB = 24;
    localparam int Q1_LSB = 16;
    localparam int Q2_LSB = 8;
    localparam int Q3_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_VER     = 3'd1,
        ST_DRAIN_V = 3'd2,
        ST_HOR     = 3'd3,
        ST_DRAIN_H = 3'd4,
        ST_DONE    = 3'd5
    } db_state_t;

    typedef struct packed {
        logic [QP_W-1:0] cur;
        logic [QP_W-1:0] left;
        logic [QP_W-1:0] top;
    } qp_set_t;

    function automatic logic [ADDR_W-1:0] db_addr(input logic dir,
                                                  input logic [LINE_CNT_W-1:0] cnt);
        return {dir, cnt};
    endfunction

    // k = edge*4 + block, which is simply the top four bits of the line counter
    function automatic logic [BS_W-1:0] bs_pick(input logic [BS_VEC_W-1:0] bs,
                                                input logic [3:0] k);
        return bs[int'(k)*BS_W +: BS_W];
    endfunction

endpackage

// File: rtl/luma_edge_feeder_db_wr_delay.sv
// Valid/address shift register that turns each buffer read into the matching
// write-back once the filtered vector returns from the pipeline.
module db_wr_delay
    import luma_edge_feeder_pkg::*;
#(
    parameter int DEPTH = DRAIN_CYC,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    adr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/luma_edge_feeder.sv
// Luma deblocking feeder: scans 4 vertical then 4 horizontal edges per MB,
// streams p3..q3 vectors with bs/qp into the filter and writes results back.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start_i; MB parameters latched on start
// VER      | 64 reads of vertical-edge lines (dir 0)
// DRAIN_V  | RD_LAT+PIPE_LAT idle cycles so vertical writes land first
// HOR      | 64 reads of horizontal-edge lines (dir 1)
// DRAIN_H  | wait for the last horizontal write
// DONE     | one-cycle done_o pulse
module luma_edge_feeder
    import luma_edge_feeder_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [QP_W-1:0]     qp_cur_i,
    input  logic [QP_W-1:0]     qp_left_i,
    input  logic [QP_W-1:0]     qp_top_i,
    input  logic [BS_VEC_W-1:0] bs_v_i,
    input  logic [BS_VEC_W-1:0] bs_h_i,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic [VEC_W-1:0]    rd_data_i,
    output logic [VEC_W-1:0]    pq_o,
    output logic [BS_W-1:0]     bs_o,
    output logic [QP_W-1:0]     qp1_o,
    output logic [QP_W-1:0]     qp2_o,
    input  logic [VEC_W-1:0]    flt_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [VEC_W-1:0]    wr_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int DRAIN_LEN = RD_LAT + PIPE_LAT;
    localparam int TMR_W     = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    db_state_t             state, state_nxt;
    logic [LINE_CNT_W-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0]      tmr, tmr_nxt;
    logic                  latch_en;
    logic                  rd_en;
    logic                  dir;
    logic                  last_line;

    qp_set_t               qp_lat;
    logic [BS_VEC_W-1:0]   bs_v_lat, bs_h_lat;

    logic [BS_W-1:0]       bs_sel, bs_q;
    logic [QP_W-1:0]       qp1_sel, qp2_sel, qp1_q, qp2_q;
    logic [ADDR_W-1:0]     rd_addr;

    assign last_line = (cnt == LINE_CNT_W'(LINES_PER_DIR - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmr_nxt   = tmr;
        latch_en  = 1'b0;
        rd_en     = 1'b0;
        dir       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    latch_en  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_VER;
                end
            end
            ST_VER: begin
                rd_en   = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (last_line) begin
                    tmr_nxt   = TMR_W'(DRAIN_LEN - 1);
                    state_nxt = ST_DRAIN_V;
                end
            end
            ST_DRAIN_V: begin
                if (tmr == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_HOR;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            ST_HOR: begin
                rd_en   = 1'b1;
                dir     = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (last_line) begin
                    tmr_nxt   = TMR_W'(DRAIN_LEN - 1);
                    state_nxt = ST_DRAIN_H;
                end
            end
            ST_DRAIN_H: begin
                if (tmr == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // MB parameters are frozen for the whole scan; a start while busy is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qp_lat   <= '0;
            bs_v_lat <= '0;
            bs_h_lat <= '0;
        end else if (latch_en) begin
            qp_lat.cur  <= qp_cur_i;
            qp_lat.left <= qp_left_i;
            qp_lat.top  <= qp_top_i;
            bs_v_lat    <= bs_v_i;
            bs_h_lat    <= bs_h_i;
        end
    end

    always_comb begin
        bs_sel  = bs_pick(dir ? bs_h_lat : bs_v_lat, cnt[LINE_CNT_W-1 -: 4]);
        qp2_sel = qp_lat.cur;
        qp1_sel = qp_lat.cur;
        if (cnt[LINE_CNT_W-1 -: 2] == 2'd0) begin
            qp1_sel = dir ? qp_lat.top : qp_lat.left;
        end
    end

    // Registered one cycle so bs/qp line up with rd_data_i; bs 0 means pass-through
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs_q  <= '0;
            qp1_q <= '0;
            qp2_q <= '0;
        end else if (rd_en) begin
            bs_q  <= bs_sel;
            qp1_q <= qp1_sel;
            qp2_q <= qp2_sel;
        end else begin
            bs_q  <= '0;
        end
    end

    assign rd_addr = db_addr(dir, cnt);

    db_wr_delay #(
        .DEPTH (DRAIN_LEN),
        .AW    (ADDR_W)
    ) u_wr_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (wr_en_o),
        .out_addr  (wr_addr_o)
    );

    assign rd_en_o   = rd_en;
    assign rd_addr_o = rd_addr;
    assign pq_o      = rd_data_i;
    assign bs_o      = bs_q;
    assign qp1_o     = qp1_q;
    assign qp2_o     = qp2_q;
    assign wr_data_o = flt_i;
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);

endmodule

// File: tb/tb_luma_edge_feeder.sv
// Bench for luma_edge_feeder: pixel buffer and 2-cycle loopback filter models,
// with a cycle-schedule reference derived from the MB timing rules.
module tb_luma_edge_feeder;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [5:0]  qp_cur_i, qp_left_i, qp_top_i;
    logic [47:0] bs_v_i, bs_h_i;
    logic        rd_en_o;
    logic [6:0]  rd_addr_o;
    logic [63:0] rd_data_i;
    logic [63:0] pq_o;
    logic [2:0]  bs_o;
    logic [5:0]  qp1_o, qp2_o;
    logic [63:0] flt_i;
    logic        wr_en_o;
    logic [6:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic        busy_o;
    logic        done_o;

    luma_edge_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .qp_cur_i  (qp_cur_i),
        .qp_left_i (qp_left_i),
        .qp_top_i  (qp_top_i),
        .bs_v_i    (bs_v_i),
        .bs_h_i    (bs_h_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .pq_o      (pq_o),
        .bs_o      (bs_o),
        .qp1_o     (qp1_o),
        .qp2_o     (qp2_o),
        .flt_i     (flt_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel buffer (1-cycle read) and filter pipeline modelled as a pure delay
    logic [63:0] mem [128];
    logic [63:0] img [128];
    logic [63:0] rd_q = '0;
    logic [63:0] f1 = '0;
    logic [63:0] f2 = '0;
    logic        load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 128; i++) mem[i] <= img[i];
        end else if (wr_en_o) begin
            mem[wr_addr_o] <= wr_data_o;
        end
        if (rd_en_o) rd_q <= mem[rd_addr_o];
        f1 <= pq_o;
        f2 <= f1;
    end
    assign rd_data_i = rd_q;
    assign flt_i     = f2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [5:0]  m_qc, m_ql, m_qt;
    logic [47:0] m_bv, m_bh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference schedule, relative to the start cycle 0
    function automatic bit is_rd(input int c);
        return (c >= 1 && c <= 64) || (c >= 68 && c <= 131);
    endfunction

    function automatic logic [6:0] raddr(input int c);
        return (c <= 64) ? 7'(c - 1) : 7'(c - 4);
    endfunction

    function automatic logic [2:0] bs_ref(input logic [6:0] a);
        int          k;
        logic [47:0] v;
        k = int'(a[5:4]) * 4 + int'(a[3:2]);
        v = a[6] ? m_bh : m_bv;
        return 3'((v >> (3 * k)) & 48'h7);
    endfunction

    function automatic logic [5:0] qp1_ref(input logic [6:0] a);
        if (a[5:4] != 2'd0) return m_qc;
        return a[6] ? m_qt : m_ql;
    endfunction

    task automatic check_cycle(input int c);
        logic [6:0] a;
        chk("rd_en", 64'(rd_en_o), 64'(is_rd(c)));
        if (is_rd(c)) chk("rd_addr", 64'(rd_addr_o), 64'(raddr(c)));
        chk("busy", 64'(busy_o), 64'(c >= 1 && c <= 135));
        chk("done", 64'(done_o), 64'(c == 135));
        if (is_rd(c - 1)) begin
            a = raddr(c - 1);
            chk("pq", pq_o, img[a]);
            chk("bs", 64'(bs_o), 64'(bs_ref(a)));
            chk("qp1", 64'(qp1_o), 64'(qp1_ref(a)));
            chk("qp2", 64'(qp2_o), 64'(m_qc));
        end else begin
            chk("bs_idle", 64'(bs_o), 64'd0);
        end
        chk("wr_en", 64'(wr_en_o), 64'(is_rd(c - 3)));
        if (is_rd(c - 3)) begin
            a = raddr(c - 3);
            chk("wr_addr", 64'(wr_addr_o), 64'(a));
            chk("wr_data", wr_data_o, img[a]);
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < 128; i++) img[i] = {$urandom, $urandom};
        load_en = 1'b1;
        step();
        load_en = 1'b0;
    endtask

    task automatic run_mb(input bit ignore_test, input int stop_at);
        qp_cur_i  = m_qc;
        qp_left_i = m_ql;
        qp_top_i  = m_qt;
        bs_v_i    = m_bv;
        bs_h_i    = m_bh;
        start_i   = 1'b1;
        for (int c = 1; c <= stop_at; c++) begin
            step();
            cyc = c;
            if (c == 1) start_i = 1'b0;
            if (ignore_test && c == 30) begin
                start_i   = 1'b1;
                qp_cur_i  = ~m_qc;
                qp_left_i = ~m_ql;
                qp_top_i  = ~m_qt;
                bs_v_i    = ~m_bv;
                bs_h_i    = ~m_bh;
            end
            if (ignore_test && c == 31) start_i = 1'b0;
            check_cycle(c);
        end
    endtask

    task automatic check_buffer();
        for (int i = 0; i < 128; i++) chk("buf", mem[i], img[i]);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        qp_cur_i  = '0;
        qp_left_i = '0;
        qp_top_i  = '0;
        bs_v_i    = '0;
        bs_h_i    = '0;
        load_image();
        step();
        step();
        rst = 1'b0;

        // Idle after reset: nothing moves
        for (int i = 0; i < 200; i++) begin
            step();
            cyc = -1;
            chk("idle_rd_en", 64'(rd_en_o), 64'd0);
            chk("idle_wr_en", 64'(wr_en_o), 64'd0);
            chk("idle_busy", 64'(busy_o), 64'd0);
            chk("idle_done", 64'(done_o), 64'd0);
            chk("idle_bs", 64'(bs_o), 64'd0);
            chk("idle_qp1", 64'(qp1_o), 64'd0);
            chk("idle_qp2", 64'(qp2_o), 64'd0);
            chk("idle_rd_addr", 64'(rd_addr_o), 64'd0);
            chk("idle_wr_addr", 64'(wr_addr_o), 64'd0);
            chk("idle_pq", pq_o, 64'd0);
        end

        // Uniform bs = 2, qp_cur = 30
        m_qc = 6'd30; m_ql = 6'd11; m_qt = 6'd50;
        for (int k = 0; k < 16; k++) begin
            m_bv[3*k +: 3] = 3'd2;
            m_bh[3*k +: 3] = 3'd2;
        end
        run_mb(1'b0, 140);
        check_buffer();

        // Edge-0 neighbour QPs and a single non-zero bs entry (edge 1, block 1)
        m_qc = 6'd30; m_ql = 6'd20; m_qt = 6'd40;
        m_bv = '0;
        m_bh = '0;
        m_bv[15 +: 3] = 3'd4;
        run_mb(1'b0, 140);
        check_buffer();

        // Random MB on a fresh image, with a start pulse while busy
        load_image();
        m_qc = 6'($urandom); m_ql = 6'($urandom); m_qt = 6'($urandom);
        m_bv = {$urandom, $urandom};
        m_bh = {$urandom, $urandom};
        run_mb(1'b1, 140);
        check_buffer();

        // Reset in the middle of the vertical pass
        load_image();
        m_qc = 6'($urandom); m_ql = 6'($urandom); m_qt = 6'($urandom);
        m_bv = {$urandom, $urandom};
        m_bh = {$urandom, $urandom};
        run_mb(1'b0, 40);
        rst = 1'b1;
        step();
        cyc = 41;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            cyc = 42 + i;
            chk("post_rst_done", 64'(done_o), 64'd0);
            chk("post_rst_busy", 64'(busy_o), 64'd0);
            chk("post_rst_wr_en", 64'(wr_en_o), 64'd0);
            chk("post_rst_rd_en", 64'(rd_en_o), 64'd0);
        end

        // Fresh start after the aborted MB runs the full schedule
        m_qc = 6'($urandom); m_ql = 6'($urandom); m_qt = 6'($urandom);
        m_bv = {$urandom, $urandom};
        m_bh = {$urandom, $urandom};
        run_mb(1'b0, 140);
        check_buffer();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
